memmu_pointcloud_mc: RTL and testbench

- Multi-channel successor to the single-cloud MemMU point-cloud address unit.
- Serves NUM_CLOUDS sensor point clouds through one shared write port:
  - accepts SIU points on a valid/ready handshake;
  - tracks a ping-pong frame bank, point count and overflow per cloud;
  - emits registered DDR write address/payload on a second valid/ready handshake;
  - generates registered read addresses for ExMU into the last completed frame.
- Sits between the SIU/representation stage and the DDR write/read masters.

---
 rtl/memmu_pkg.sv | 29 ++
 rtl/memmu_cloud_ctx.sv | 35 +++
 rtl/memmu_pointcloud_mc.sv | 133 +++++++++++++
 tb/tb_memmu_pointcloud_mc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/memmu_pkg.sv
// Shared types and helpers for the multi-channel MemMU point-cloud address unit.
package memmu_pkg;

    localparam int unsigned MEMMU_ID_W  = 19;
    localparam int unsigned MEMMU_CNT_W = MEMMU_ID_W + 1;

    // Per-cloud frame context: write bank, running count, last frame size, sticky overflow
    typedef struct packed {
        logic                   bank;
        logic [MEMMU_CNT_W-1:0] count;
        logic [MEMMU_CNT_W-1:0] size;
        logic                   overflow;
    } cloudCtx_t;

    // Byte distance between the two ping-pong banks of one cloud
    function automatic logic [63:0] bankStride(input int unsigned idW,
                                               input int unsigned ptBytesLog2);
        return 64'd1 << (idW + ptBytesLog2);
    endfunction

    // Ceiling log2, minimum 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return result;
    endfunction

endpackage

// File: rtl/memmu_cloud_ctx.sv
// One cloud's frame context: bank toggle, point count, size latch, sticky overflow.
module memmu_cloud_ctx
    import memmu_pkg::*;
#(
    parameter int unsigned MAX_POINTS = 4096
) (
    input  logic      i_SYSTEM_clk,
    input  logic      i_SYSTEM_rst,
    input  logic      hit,
    input  logic      newFrame,
    input  logic      inRange,
    output cloudCtx_t ctx
);

    cloudCtx_t ctxQ;

    // Update context on every accepted point addressed to this cloud
    always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
        if (i_SYSTEM_rst) begin
            ctxQ <= '0;
        end else if (hit) begin
            if (newFrame) begin
                ctxQ.bank  <= ~ctxQ.bank;
                ctxQ.size  <= ctxQ.count;
                ctxQ.count <= inRange ? MEMMU_CNT_W'(1) : '0;
            end else if (inRange && (32'(ctxQ.count) < MAX_POINTS)) begin
                ctxQ.count <= ctxQ.count + MEMMU_CNT_W'(1);
            end
            if (!inRange) ctxQ.overflow <= 1'b1;
        end
    end

    assign ctx = ctxQ;

endmodule

// File: rtl/memmu_pointcloud_mc.sv
// Multi-channel MemMU point-cloud address unit: shared write port, per-cloud
// ping-pong banks, registered DDR write beat and ExMU read address.
// Build option: MEMMU_P_DOUBLE_BUFFER_EN enables ping-pong bank addressing.
module memmu_pointcloud_mc
    import memmu_pkg::*;
#(
    parameter int unsigned NUM_CLOUDS    = 2,
    parameter int unsigned ID_W          = MEMMU_ID_W,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned PAYLOAD_W     = 64,
    parameter int unsigned PT_BYTES_LOG2 = 3,
    parameter int unsigned MAX_POINTS    = 4096,
    parameter int unsigned CSEL_W        = 3
) (
    input  logic                         i_SYSTEM_clk,
    input  logic                         i_SYSTEM_rst,
    input  logic [NUM_CLOUDS*ADDR_W-1:0] i_MonU_MemMU_base,
    input  logic                         i_SIU_valid,
    output logic                         o_SIU_ready,
    input  logic [CSEL_W-1:0]            i_SIU_cloudSel,
    input  logic [ID_W-1:0]              i_SIU_pointID,
    input  logic                         i_SIU_newFrame,
    input  logic [PAYLOAD_W-1:0]         i_SIU_payload,
    output logic                         o_MemMU_P_writeValid,
    input  logic                         i_MEM_writeReady,
    output logic [ADDR_W-1:0]            o_MemMU_P_writeAddress,
    output logic [PAYLOAD_W-1:0]         o_MemMU_P_writePayload,
    input  logic [CSEL_W-1:0]            i_ExMU_readCloudSel,
    input  logic [ID_W-1:0]              i_ExMU_pointReadID,
    output logic [ADDR_W-1:0]            o_MemMU_P_readAddress,
    output logic [NUM_CLOUDS-1:0]        o_MemMU_P_frame,
    output logic [NUM_CLOUDS*(ID_W+1)-1:0] o_MemMU_P_size,
    output logic [NUM_CLOUDS-1:0]        o_MemMU_P_overflow
);

    localparam logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(bankStride(ID_W, PT_BYTES_LOG2));

    cloudCtx_t             ctx [NUM_CLOUDS];
    logic                  wValid;
    logic [ADDR_W-1:0]     wAddr;
    logic [PAYLOAD_W-1:0]  wPayload;
    logic [ADDR_W-1:0]     rAddr;
    logic                  accept;
    logic                  selOk;
    logic                  inRange;
    logic                  readSelOk;
    logic                  writeBank;
    logic                  readBank;
    logic [ADDR_W-1:0]     writeBase;
    logic [ADDR_W-1:0]     readBase;
    logic [ADDR_W-1:0]     writeAddrNext;
    logic [ADDR_W-1:0]     readAddrNext;

    assign o_SIU_ready = !wValid || i_MEM_writeReady;
    assign accept      = i_SIU_valid && o_SIU_ready;
    assign selOk       = 32'(i_SIU_cloudSel) < NUM_CLOUDS;
    assign readSelOk   = 32'(i_ExMU_readCloudSel) < NUM_CLOUDS;
    assign inRange     = 32'(i_SIU_pointID) < MAX_POINTS;

    for (genvar k = 0; k < NUM_CLOUDS; k++) begin : g_cloud
        memmu_cloud_ctx #(
            .MAX_POINTS (MAX_POINTS)
        ) u_ctx (
            .i_SYSTEM_clk (i_SYSTEM_clk),
            .i_SYSTEM_rst (i_SYSTEM_rst),
            .hit          (accept && selOk && (32'(i_SIU_cloudSel) == 32'(k))),
            .newFrame     (i_SIU_newFrame),
            .inRange      (inRange),
            .ctx          (ctx[k])
        );
        assign o_MemMU_P_frame[k]                        = ctx[k].bank;
        assign o_MemMU_P_size[k*(ID_W+1) +: (ID_W+1)]    = (ID_W+1)'(ctx[k].size);
        assign o_MemMU_P_overflow[k]                     = ctx[k].overflow;
    end

    // Select base and bank for the write cloud and the read cloud
    always_comb begin
        writeBase = '0;
        readBase  = '0;
        writeBank = 1'b0;
        readBank  = 1'b0;
        for (int unsigned k = 0; k < NUM_CLOUDS; k++) begin
            if (32'(i_SIU_cloudSel) == k) begin
                writeBase = i_MonU_MemMU_base[k*ADDR_W +: ADDR_W];
`ifdef MEMMU_P_DOUBLE_BUFFER_EN
                // a newFrame point lands in the bank it is about to toggle into
                writeBank = i_SIU_newFrame ? ~ctx[k].bank : ctx[k].bank;
`endif
            end
            if (32'(i_ExMU_readCloudSel) == k) begin
                readBase = i_MonU_MemMU_base[k*ADDR_W +: ADDR_W];
`ifdef MEMMU_P_DOUBLE_BUFFER_EN
                // completed frame lives in the bank opposite the pre-toggle write bank
                readBank = ~ctx[k].bank;
`endif
            end
        end
    end

    assign writeAddrNext = writeBase + (writeBank ? BANK_OFFSET : '0)
                         + (ADDR_W'(i_SIU_pointID) << PT_BYTES_LOG2);
    assign readAddrNext  = readBase + (readBank ? BANK_OFFSET : '0)
                         + (ADDR_W'(i_ExMU_pointReadID) << PT_BYTES_LOG2);

    // Write beat register: load on accept, hold while stalled, clear when drained
    always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
        if (i_SYSTEM_rst) begin
            wValid   <= 1'b0;
            wAddr    <= '0;
            wPayload <= '0;
        end else if (accept) begin
            wValid <= selOk && inRange;
            if (selOk && inRange) begin
                wAddr    <= writeAddrNext;
                wPayload <= i_SIU_payload;
            end
        end else if (i_MEM_writeReady) begin
            wValid <= 1'b0;
        end
    end

    // Read address register, zero for an unmapped cloud
    always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
        if (i_SYSTEM_rst) rAddr <= '0;
        else              rAddr <= readSelOk ? readAddrNext : '0;
    end

    assign o_MemMU_P_writeValid   = wValid;
    assign o_MemMU_P_writeAddress = wAddr;
    assign o_MemMU_P_writePayload = wPayload;
    assign o_MemMU_P_readAddress  = rAddr;

endmodule

// File: tb/tb_memmu_pointcloud_mc.sv
// Self-checking bench for memmu_pointcloud_mc with a queue-based reference model.
module tb_memmu_pointcloud_mc;

    localparam int unsigned NC   = 2;
    localparam int unsigned IDW  = 19;
    localparam int unsigned AW   = 32;
    localparam int unsigned PW   = 64;
    localparam int unsigned MAXP = 4096;
    localparam int unsigned CSW  = 3;
`ifdef MEMMU_P_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NC*AW-1:0]      baseBus = {32'h2000_0000, 32'h1000_0000};
    logic                  siuValid = 1'b0;
    logic                  siuReady;
    logic [CSW-1:0]        siuSel = '0;
    logic [IDW-1:0]        siuId = '0;
    logic                  siuNf = 1'b0;
    logic [PW-1:0]         siuPl = '0;
    logic                  wValid;
    logic                  memReady = 1'b0;
    logic [AW-1:0]         wAddr;
    logic [PW-1:0]         wPl;
    logic [CSW-1:0]        rSel = '0;
    logic [IDW-1:0]        rId = '0;
    logic [AW-1:0]         rAddr;
    logic [NC-1:0]         frame;
    logic [NC*(IDW+1)-1:0] sizeBus;
    logic [NC-1:0]         ovf;

    always #5 clk = ~clk;

    memmu_pointcloud_mc #(
        .NUM_CLOUDS(NC), .ID_W(IDW), .ADDR_W(AW), .PAYLOAD_W(PW),
        .PT_BYTES_LOG2(3), .MAX_POINTS(MAXP), .CSEL_W(CSW)
    ) dut (
        .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .i_MonU_MemMU_base(baseBus),
        .i_SIU_valid(siuValid), .o_SIU_ready(siuReady), .i_SIU_cloudSel(siuSel),
        .i_SIU_pointID(siuId), .i_SIU_newFrame(siuNf), .i_SIU_payload(siuPl),
        .o_MemMU_P_writeValid(wValid), .i_MEM_writeReady(memReady),
        .o_MemMU_P_writeAddress(wAddr), .o_MemMU_P_writePayload(wPl),
        .i_ExMU_readCloudSel(rSel), .i_ExMU_pointReadID(rId),
        .o_MemMU_P_readAddress(rAddr), .o_MemMU_P_frame(frame),
        .o_MemMU_P_size(sizeBus), .o_MemMU_P_overflow(ovf)
    );

    int unsigned nChecks = 0;
    int unsigned nFails  = 0;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] base [NC] = '{32'h1000_0000, 32'h2000_0000};
    bit          mBank [NC];
    int unsigned mCnt  [NC];
    int unsigned mSize [NC];
    bit          mOvf  [NC];
    logic [31:0] qAddr [$];
    logic [63:0] qData [$];
    logic [31:0] expRead = '0;

    function automatic logic [31:0] modelAddr(input int unsigned c, input bit b, input int unsigned id);
        logic [31:0] a;
        a = base[c] + ((DB && b) ? 32'h0040_0000 : 32'h0) + id * 8;
        return a;
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NC; c++) begin
            mBank[c] = 1'b0; mCnt[c] = 0; mSize[c] = 0; mOvf[c] = 1'b0;
        end
        qAddr.delete();
        qData.delete();
        expRead = '0;
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_wValid"}, wValid, 0);
        checkValue({tag, "_wAddr"}, wAddr, 0);
        checkValue({tag, "_wPayload"}, wPl, 0);
        checkValue({tag, "_rAddr"}, rAddr, 0);
        checkValue({tag, "_frame"}, frame, 0);
        checkValue({tag, "_size"}, sizeBus, 0);
        checkValue({tag, "_overflow"}, ovf, 0);
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model
    task automatic step(input bit v, input int unsigned sel, input int unsigned id, input bit nf,
                        input logic [63:0] pl, input bit wr, input int unsigned rsel,
                        input int unsigned rid);
        bit expReady;
        bit inr;
        siuValid = v; siuSel = CSW'(sel); siuId = IDW'(id); siuNf = nf; siuPl = pl;
        memReady = wr; rSel = CSW'(rsel); rId = IDW'(rid);
        #1;
        checkValue("readAddress", rAddr, expRead);
        expReady = (qAddr.size() == 0) || wr;
        checkValue("siuReady", siuReady, expReady);
        checkValue("writeValid", wValid, qAddr.size() != 0);
        if (qAddr.size() != 0) begin
            checkValue("writeAddress", wAddr, qAddr[0]);
            checkValue("writePayload", wPl, qData[0]);
        end
        for (int c = 0; c < NC; c++) begin
            checkValue("frame", frame[c], mBank[c]);
            checkValue("size", sizeBus[c*(IDW+1) +: (IDW+1)], mSize[c]);
            checkValue("overflow", ovf[c], mOvf[c]);
        end
        if (qAddr.size() != 0 && wr) begin
            void'(qAddr.pop_front());
            void'(qData.pop_front());
        end
        expRead = (rsel < NC) ? modelAddr(rsel, !mBank[rsel], rid) : 32'h0;
        if (v && expReady && sel < NC) begin
            inr = id < MAXP;
            if (nf) begin
                mBank[sel] = !mBank[sel];
                mSize[sel] = mCnt[sel];
                mCnt[sel]  = inr ? 1 : 0;
            end else if (inr && mCnt[sel] < MAXP) begin
                mCnt[sel]++;
            end
            if (!inr) mOvf[sel] = 1'b1;
            else begin
                qAddr.push_back(modelAddr(sel, mBank[sel], id));
                qData.push_back(pl);
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit wr);
        step(1'b0, 0, 0, 1'b0, 64'h0, wr, 0, 0);
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        checkAllZero("reset");
        rst = 1'b0;

        // First point of a frame on cloud 0
        step(1'b1, 0, 5, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, 0, 0);
        checkValue("t1_frame0", frame[0], 1);
        checkValue("t1_addr", wAddr, DB ? 32'h1040_0028 : 32'h1000_0028);
        checkValue("t1_payload", wPl, 64'hDEAD_BEEF_0123_4567);
        idle(1'b1);

        // 100-point frame then a new frame
        for (int i = 0; i < 100; i++)
            step(1'b1, 0, i, i == 0, {$urandom, $urandom}, 1'b1, 0, i);
        step(1'b1, 0, 0, 1'b1, {$urandom, $urandom}, 1'b1, 0, 0);
        checkValue("t2_size0", sizeBus[IDW:0], 100);

        // Downstream stall with SIU valid held, then drain
        for (int i = 0; i < 4; i++)
            step(1'b1, 0, 200 + i, 1'b0, {$urandom, $urandom}, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 0, 300 + i, 1'b0, {$urandom, $urandom}, 1'b1, 0, 0);
        idle(1'b1);

        // Overflow on cloud 1 with newFrame
        step(1'b1, 1, 4096, 1'b1, 64'h1, 1'b1, 0, 0);
        checkValue("t4_overflow", ovf, 2'b10);
        checkValue("t4_noBeat", wValid, 0);
        idle(1'b1);

        // Read cloud 1 completed frame
        step(1'b0, 0, 0, 1'b0, 64'h0, 1'b1, 1, 2);
        if (DB) checkValue("t5_read", rAddr, 32'h2000_0010);
        idle(1'b1);

        // Asynchronous reset in the middle of a stall
        step(1'b1, 0, 7, 1'b0, 64'h77, 1'b0, 0, 0);
        idle(1'b0);
        #2 rst = 1'b1;
        #1 checkAllZero("asyncRst");
        modelReset();
        #2 rst = 1'b0;
        step(1'b1, 0, 3, 1'b0, 64'h33, 1'b1, 0, 0);
        checkValue("t6_addr", wAddr, 32'h1000_0018);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int unsigned id;
            id = ($urandom_range(0, 19) == 0) ? $urandom_range(MAXP, MAXP + 50)
                                              : $urandom_range(0, MAXP - 1);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), id,
                 $urandom_range(0, 15) == 0, {$urandom, $urandom},
                 $urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 524287));
        end
        idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
